// File: rtl/scatter_tile_sched.sv
// Handshake controller that gates one tensor of NUM_BLOCKS blocks into scatter and forks
// every scatter output beat to the large and small consumers; the data buses bypass it.
module scatter_tile_sched #(
  parameter int NUM_BLOCKS = 8,
  parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  output logic             sc_in_valid_o,
  input  logic             sc_in_ready_i,
  input  logic             sc_out_valid_i,
  output logic             sc_out_ready_o,
  output logic             large_valid_o,
  input  logic             large_ready_i,
  output logic             small_valid_o,
  input  logic             small_ready_i,
  output logic [CNT_W-1:0] issued_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [CNT_W-1:0] NB    = CNT_W'(NUM_BLOCKS);
  localparam logic [CNT_W-1:0] NB_M1 = CNT_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             taken_l_q, taken_l_d;
  logic             taken_s_q, taken_s_d;
  logic             issue, retire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      issued_q  <= '0;
      retired_q <= '0;
      taken_l_q <= 1'b0;
      taken_s_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      taken_l_q <= taken_l_d;
      taken_s_q <= taken_s_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    issued_d       = issued_q;
    retired_d      = retired_q;
    taken_l_d      = taken_l_q;
    taken_s_d      = taken_s_q;
    issue          = 1'b0;
    retire         = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    up_ready_o     = 1'b0;
    sc_in_valid_o  = 1'b0;
    sc_out_ready_o = 1'b0;
    large_valid_o  = 1'b0;
    small_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          issued_d  = '0;
          retired_d = '0;
          taken_l_d = 1'b0;
          taken_s_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        busy_o        = 1'b1;
        issue         = (issued_q < NB);
        sc_in_valid_o = up_valid_i & issue;
        up_ready_o    = sc_in_ready_i & issue;
        if (sc_in_valid_o && sc_in_ready_i) issued_d = issued_q + ONE;
        // A consumer that already took this beat no longer holds the fork back.
        large_valid_o  = sc_out_valid_i & ~taken_l_q;
        small_valid_o  = sc_out_valid_i & ~taken_s_q;
        sc_out_ready_o = (large_ready_i | taken_l_q) & (small_ready_i | taken_s_q);
        retire         = sc_out_valid_i & sc_out_ready_o;
        if (retire) begin
          retired_d = retired_q + ONE;
          taken_l_d = 1'b0;
          taken_s_d = 1'b0;
          if (retired_q == NB_M1) state_d = DONE;
        end else begin
          if (large_valid_o && large_ready_i) taken_l_d = 1'b1;
          if (small_valid_o && small_ready_i) taken_s_d = 1'b1;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign issued_cnt_o  = issued_q;
  assign retired_cnt_o = retired_q;

  cnt_order_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (retired_q <= issued_q) && (issued_q <= NB));

endmodule

// File: tb/tb_scatter_tile_sched.sv
// Directed bench for scatter_tile_sched (NUM_BLOCKS=4) with a 1-cycle scatter model and
// a monitor that tracks per-consumer beat order, done pulses and counter ordering.
module tb_scatter_tile_sched;
  logic       clk, rst_n, start;
  logic       busy, done, up_valid, up_ready, sc_in_valid, sc_in_ready;
  logic       sc_out_valid, sc_out_ready, large_valid, large_ready, small_valid, small_ready;
  logic [2:0] issued_cnt, retired_cnt;

  int n_cmp = 0, n_err = 0;

  scatter_tile_sched #(.NUM_BLOCKS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .up_valid_i(up_valid), .up_ready_o(up_ready),
    .sc_in_valid_o(sc_in_valid), .sc_in_ready_i(sc_in_ready),
    .sc_out_valid_i(sc_out_valid), .sc_out_ready_o(sc_out_ready),
    .large_valid_o(large_valid), .large_ready_i(large_ready),
    .small_valid_o(small_valid), .small_ready_i(small_ready),
    .issued_cnt_o(issued_cnt), .retired_cnt_o(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scatter model: FIFO of upstream tags, output valid one cycle after acceptance.
  int sq_mem [64];
  int sq_wr, sq_rd, up_tag, up_acc, l_exp, s_exp, l_seen, s_seen, l_err, s_err, done_cnt, inv_err;
  assign sc_out_valid = (sq_wr != sq_rd);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_wr <= 0; sq_rd <= 0; up_tag <= 0; up_acc <= 0;
      l_exp <= 0; s_exp <= 0; l_seen <= 0; s_seen <= 0;
      l_err <= 0; s_err <= 0; done_cnt <= 0; inv_err <= 0;
    end else begin
      if (up_valid && up_ready) begin up_acc <= up_acc + 1; up_tag <= up_tag + 1; end
      if (sc_in_valid && sc_in_ready) begin sq_mem[sq_wr[5:0]] <= up_tag; sq_wr <= sq_wr + 1; end
      if (large_valid && large_ready) begin
        if (sq_mem[sq_rd[5:0]] != l_exp) l_err <= l_err + 1;
        l_exp <= l_exp + 1; l_seen <= l_seen + 1;
      end
      if (small_valid && small_ready) begin
        if (sq_mem[sq_rd[5:0]] != s_exp) s_err <= s_err + 1;
        s_exp <= s_exp + 1; s_seen <= s_seen + 1;
      end
      if (sc_out_valid && sc_out_ready) sq_rd <= sq_rd + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (retired_cnt > issued_cnt || issued_cnt > 3'd4) inv_err <= inv_err + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs until done is seen, bounded; ends in the DONE cycle.
  task automatic wait_done(input string tag, input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      tick(); #1;
      if (done) break;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ua, dc, ls0;

  initial begin
    rst_n = 1'b0; start = 1'b0; up_valid = 1'b0; sc_in_ready = 1'b0;
    large_ready = 1'b0; small_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_up_ready", up_ready, 0);  chk("rst_sc_in_valid", sc_in_valid, 0);
    chk("rst_sc_out_ready", sc_out_ready, 0);
    chk("rst_large_valid", large_valid, 0); chk("rst_small_valid", small_valid, 0);
    chk("rst_issued", issued_cnt, 0);  chk("rst_retired", retired_cnt, 0);
    rst_n = 1'b1;

    // Idle without start: upstream must never see ready.
    up_valid = 1'b1; sc_in_ready = 1'b1; large_ready = 1'b1; small_ready = 1'b1;
    repeat (3) tick();
    #1 chk("idle_up_ready", up_ready, 0); chk("idle_busy", busy, 0);

    // Start, one issue, then reset mid-RUN.
    start = 1'b1; tick(); start = 1'b0;
    #1 chk("start_up_ready", up_ready, 1); chk("start_busy", busy, 1);
    chk("start_sc_in_valid", sc_in_valid, 1);
    tick(); #1 chk("prerst_issued", issued_cnt, 1);
    rst_n = 1'b0; #1;
    chk("midrst_issued", issued_cnt, 0); chk("midrst_busy", busy, 0);
    chk("midrst_up_ready", up_ready, 0); chk("midrst_large_valid", large_valid, 0);
    tick(); rst_n = 1'b1;
    tick(); #1 chk("postrst_done", done, 0); chk("postrst_busy", busy, 0);

    // Full throughput: all readys held high.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      chk("t2_issued", issued_cnt, k);
      chk("t2_retired", retired_cnt, k - 1);
    end
    chk("t2_sat_up_ready", up_ready, 0);
    tick(); #1;
    chk("t2_done", done, 1); chk("t2_done_busy", busy, 1);
    chk("t2_done_retired", retired_cnt, 4); chk("t2_done_sc_out_ready", sc_out_ready, 0);
    tick(); #1;
    chk("t2_after_done", done, 0); chk("t2_after_busy", busy, 0);
    chk("t2_hold_issued", issued_cnt, 4); chk("t2_hold_retired", retired_cnt, 4);
    chk("t2_done_cnt", done_cnt, 1); chk("t2_up_acc", up_acc, 4);
    chk("t2_l_seen", l_seen, 4); chk("t2_s_seen", s_seen, 4);

    // Skewed consumers: small held off for 3 cycles.
    up_valid = 1'b0; small_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0; up_valid = 1'b1;
    #1 chk("t3_up_ready", up_ready, 1);
    tick(); up_valid = 1'b0;
    #1 chk("t3_a_large_valid", large_valid, 1); chk("t3_a_small_valid", small_valid, 1);
    chk("t3_a_sc_out_ready", sc_out_ready, 0);
    tick();
    #1 chk("t3_b_large_valid", large_valid, 0); chk("t3_b_small_valid", small_valid, 1);
    chk("t3_b_sc_out_ready", sc_out_ready, 0); chk("t3_b_retired", retired_cnt, 0);
    tick();
    #1 chk("t3_c_large_valid", large_valid, 0); chk("t3_c_sc_out_ready", sc_out_ready, 0);
    small_ready = 1'b1;
    #1 chk("t3_d_sc_out_ready", sc_out_ready, 1); chk("t3_d_large_valid", large_valid, 0);
    tick();
    #1 chk("t3_retired", retired_cnt, 1); chk("t3_l_seen", l_seen, 5);
    chk("t3_s_seen", s_seen, 5); chk("t3_l_err", l_err, 0);
    up_valid = 1'b1;
    wait_done("t3_done_seen", 50);
    chk("t3_issued", issued_cnt, 4); chk("t3_fin_retired", retired_cnt, 4);
    tick();

    // Overrun: upstream keeps offering; only 4 accepted per tensor.
    #1 chk("t4_idle_up_ready", up_ready, 0);
    ua = up_acc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    #1 chk("t4_sat_issued", issued_cnt, 4); chk("t4_sat_up_ready", up_ready, 0);
    wait_done("t4_done_seen", 20);
    tick(); tick();
    #1 chk("t4_accepted", up_acc - ua, 4); chk("t4_pending_up_ready", up_ready, 0);

    // Start pulses in RUN and DONE must be ignored.
    dc = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    tick(); #1 chk("t5_issued1", issued_cnt, 1);
    start = 1'b1; tick(); start = 1'b0;
    #1 chk("t5_issued2", issued_cnt, 2); chk("t5_busy", busy, 1);
    wait_done("t5_done_seen", 20);
    start = 1'b1; tick(); start = 1'b0;
    #1 chk("t5_idle_busy", busy, 0); chk("t5_hold_issued", issued_cnt, 4);
    chk("t5_hold_retired", retired_cnt, 4);
    tick(); #1 chk("t5_still_idle", busy, 0);
    chk("t5_one_done", done_cnt - dc, 1);

    // Random back-pressure, 200 tensors.
    dc = done_cnt; ls0 = l_seen; ua = up_acc;
    for (int t = 0; t < 200; t++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int n = 0; n < 200; n++) begin
        up_valid    = ($urandom_range(0, 3) != 0);
        sc_in_ready = ($urandom_range(0, 3) != 0);
        large_ready = ($urandom_range(0, 3) != 0);
        small_ready = ($urandom_range(0, 3) != 0);
        tick(); #1;
        if (done) break;
      end
      chk("t6_done", done, 1);
      tick();
    end
    #1;
    chk("t6_done_cnt", done_cnt - dc, 200);
    chk("t6_l_beats", l_seen - ls0, 800); chk("t6_s_seen_eq", s_seen, l_seen);
    chk("t6_accept_eq", up_acc - ua, 800);
    chk("t6_l_order", l_err, 0); chk("t6_s_order", s_err, 0);
    chk("t6_invariant", inv_err, 0);
    chk("t6_issued", issued_cnt, 4); chk("t6_retired", retired_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
